// File: rtl/wave_sequencer_if.sv
// Sample stream from the wave sequencer to its downstream consumer (DAC/PWM).
// A sample transfers on any clock edge where sample_valid and sample_ready are both high.
interface wave_sequencer_if;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       sample_ready;

  modport master (output sample_out, output sample_valid, input sample_ready);
  modport slave  (input sample_out, input sample_valid, output sample_ready);
endinterface

// File: rtl/wave_sequencer.sv
// Phase-accumulator sequencer for the 8-bit waveform generator: drives count,
// muxes the selected generator output and streams it, in continuous or burst mode.
module wave_sequencer #(
  parameter int PHASE_W = 16,
  parameter int BURST_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [2:0]         wave_sel,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [7:0]         square,
  input  logic [7:0]         triangle,
  input  logic [7:0]         reciprocal,
  input  logic [7:0]         sin,
  input  logic [7:0]         full,
  input  logic [7:0]         half,
  output logic [7:0]         count,
  wave_sequencer_if.master   stream,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] periods_done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q;
  logic [PHASE_W-1:0]   freq_q;
  logic [2:0]           sel_q;
  logic [BURST_W-1:0]   burst_q;
  logic                 stop_pending;
  logic [7:0]           sample_q;
  logic                 valid_q;
  logic                 done_q;
  logic [BURST_W-1:0]   periods_q;

  logic [PHASE_W:0]     phase_sum;
  logic [BURST_W:0]     periods_inc;
  logic                 step;
  logic                 wrap;
  logic                 last_period;
  logic                 finish_ok;
  logic [7:0]           wave;

  assign phase_sum   = {1'b0, phase_q} + {1'b0, freq_q};
  assign periods_inc = {1'b0, periods_q} + (BURST_W+1)'(1);
  assign count       = phase_q[PHASE_W-1 -: 8];

  assign stream.sample_out   = sample_q;
  assign stream.sample_valid = valid_q;
  assign busy                = (state_q != IDLE);
  assign done                = done_q;
  assign periods_done        = periods_q;
  assign state_dbg           = state_q;

  always_comb begin
    wave = 8'd0;
    case (sel_q)
      3'd0:    wave = square;
      3'd1:    wave = triangle;
      3'd2:    wave = reciprocal;
      3'd3:    wave = sin;
      3'd4:    wave = full;
      3'd5:    wave = half;
      default: wave = 8'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A step advances the phase whenever the output register is free or being drained.
  always_comb begin
    state_d     = state_q;
    step        = 1'b0;
    wrap        = 1'b0;
    last_period = 1'b0;
    finish_ok   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        step        = !(valid_q && !stream.sample_ready);
        wrap        = step && phase_sum[PHASE_W];
        last_period = (burst_q != '0) && (periods_inc == {1'b0, burst_q});
        if (wrap && (stop_pending || last_period)) state_d = FINISH;
      end
      FINISH: begin
        finish_ok = !valid_q || stream.sample_ready;
        if (finish_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q      <= '0;
      freq_q       <= '0;
      sel_q        <= '0;
      burst_q      <= '0;
      stop_pending <= 1'b0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      periods_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            freq_q       <= freq_word;
            sel_q        <= wave_sel;
            burst_q      <= burst_len;
            phase_q      <= '0;
            periods_q    <= '0;
            stop_pending <= 1'b0;
          end
        end
        RUN: begin
          if (stop) stop_pending <= 1'b1;
          if (step) begin
            sample_q <= wave;
            valid_q  <= 1'b1;
            phase_q  <= phase_sum[PHASE_W-1:0];
            // Reconfiguration only takes effect at a period boundary.
            if (wrap) begin
              if (!(&periods_q)) periods_q <= periods_q + BURST_W'(1);
              freq_q <= freq_word;
              sel_q  <= wave_sel;
            end
          end
        end
        FINISH: begin
          if (valid_q && stream.sample_ready) valid_q <= 1'b0;
          if (finish_ok) begin
            done_q       <= 1'b1;
            phase_q      <= '0;
            stop_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
Controller for the 8-bit waveform generator datapath. It drives the generator's `count` input from a phase accumulator, so the output frequency is programmable. It selects one of the six generator outputs and streams the chosen sample to a downstream consumer (DAC/PWM) over a valid/ready handshake. It supports continuous or burst (N-period) operation, with graceful stop and glitch-free reconfiguration at period boundaries.

Parameters:
PHASE_W, 16, phase accumulator width; count = phase[PHASE_W-1 -: 8]; must be >= 8
BURST_W, 8, width of burst length and period counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle start request
stop  in  1  single-cycle graceful stop request
freq_word  in  PHASE_W  phase increment per accepted step
wave_sel  in  3  0 square, 1 triangle, 2 reciprocal, 3 sin, 4 full, 5 half, 6/7 output 0
burst_len  in  BURST_W  periods to play; 0 = continuous
square, triangle, reciprocal, sin, full, half  in  8 each  generator outputs for current count
count  out  8  count driven to generator
sample_out  out  8  registered selected sample
sample_valid  out  1  sample_out holds an unaccepted sample
sample_ready  in  1  consumer accepts when high with sample_valid
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on completion
periods_done  out  BURST_W  completed periods in current run, saturating

Behaviour:
- Reset (async, any state): state IDLE; phase 0, count 0, sample_out 0, sample_valid 0, busy 0, done 0, periods_done 0, stop_pending 0; latched freq/sel cleared to 0.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 -> RUN next cycle; latch freq_word, wave_sel, burst_len; phase 0; periods_done 0.
  - stop in IDLE is ignored.
- Step: a cycle in RUN where !(sample_valid && !sample_ready). On a step:
  - sample_out <= waveform(latched sel) for the current count.
  - sample_valid <= 1.
  - phase <= phase + latched freq (modulo 2^PHASE_W).
- Stall: no step -> phase, count, sample_out frozen; sample_valid held at 1.
- Latency: start at cycle N -> RUN at N+1 with count 0 -> sample_valid=1 at N+2 with waveform(0).
- sample_valid falls on a cycle where valid&&ready and no new step occurs (FINISH or IDLE).
- Wrap: carry out of the phase add on a step.
  - periods_done increments, saturating at 2^BURST_W-1.
  - freq_word and wave_sel are re-latched from the inputs; changes applied mid-period are invisible until the wrap.
  - If stop_pending, or burst_len != 0 and periods_done+1 == burst_len -> FINISH. The wrapping step's sample is still emitted.
- stop in RUN sets stop_pending; the run ends at the next wrap, never mid-period. start in RUN or FINISH is ignored.
- FINISH:
  - No steps.
  - When sample_valid==0, or a transfer completes this cycle: done=1 for one cycle, state IDLE, phase and count 0.
  - periods_done holds its value until the next start.
- Simultaneous start and stop in IDLE: start wins and stop is dropped. stop on the same cycle as a wrap that already ends a burst has no extra effect.
- freq_word=0 while running: count stays constant, no wrap occurs, and the run ends only on reset. This is intended and is not a hardware error.
- Waveform mux is combinational from the generator outputs. sin/full/half are sampled as-is at each step; sequencer step rate does not gate the generator's oscillator.

Test Plan:
- freq_word=0x0100, sel=0, burst_len=1, ready=1, start at cycle 0 -> 256 valid samples from cycle 2: 128 of 0 then 128 of 255. done pulses once at cycle 258, busy low after, periods_done=1.
- Same config, ready low for 5 cycles while count=40 -> sample_out and count frozen for 5 cycles, valid held high; no sample lost or duplicated; total still 256.
- sel=1 (triangle), burst_len=2; change wave_sel to 0 at count 64 of period 1 -> period 1 is pure triangle (0,2,4,…,254,254,…,0); period 2 is pure square.
- freq_word=0x8000, burst_len=3 -> count sequence 0,128 repeated; exactly 6 samples 0,255,0,255,0,255 (sel=0); done after the 6th transfer.
- burst_len=0, stop at count 100 -> samples continue through count 255, then FINISH; done pulses; periods_done=1; a start pulsed mid-run is ignored.
- Assert reset during RUN with valid pending -> same cycle: sample_valid=0, count=0, busy=0; after release the block is idle until start.
